// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, line levels, FSM encoding and baud helper.
// Used by both the transmit and receive paths.
package uart_pkg;

  localparam int   UART_DATA_BITS   = 8;
  localparam logic UART_START_LEVEL = 1'b0;
  localparam logic UART_STOP_LEVEL  = 1'b1;
  localparam logic UART_IDLE_LEVEL  = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP
  } uart_state_e;

  // Integer-truncated clock cycles per line bit.
  function automatic int cycles_per_bit(input int clock_frequency, input int baud_rate);
    return clock_frequency / baud_rate;
  endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Byte-stream valid/ready handshake feeding the UART transmitter.
interface uart_transmitter_if;
  import uart_pkg::*;

  logic [UART_DATA_BITS-1:0] transmit_data;
  logic                      transmit_valid;
  logic                      transmit_ready;

  modport master (output transmit_data, output transmit_valid, input  transmit_ready);
  modport slave  (input  transmit_data, input  transmit_valid, output transmit_ready);

endinterface

// File: rtl/uart_transmit_fifo.sv
// Synchronous FIFO with extra-MSB pointers; full/empty come straight from pointer compare.
module uart_transmit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic             empty_next
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr;
  logic [AW:0]      wr_ptr_n, rd_ptr_n;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push, do_pop;

  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty = (wr_ptr == rd_ptr);

  // Overflow/underflow requests are ignored rather than corrupting pointers.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_n = wr_ptr + {{AW{1'b0}}, do_push};
    rd_ptr_n = rd_ptr + {{AW{1'b0}}, do_pop};
  end

  // Occupancy after the coming edge, so the owner can register an exact busy flag.
  assign empty_next = (wr_ptr_n == rd_ptr_n);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign pop_data = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/uart_transmitter.sv
// UART transmit path: FIFO-buffered bytes serialised as 8N1/8N2 frames, LSB first.
// FSM, baud counter, bit counter and shift register live here; buffering is in the FIFO.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int BAUD_RATE       = 9600,
  parameter int CLOCK_FREQUENCY = 100000000,
  parameter int FIFO_DEPTH      = 4,
  parameter int STOP_BITS       = 1
) (
  input  logic                clock,
  input  logic                reset,
  uart_transmitter_if.slave   tx,
  output logic                transmit_uart,
  output logic                busy
);

  localparam int CPB   = cycles_per_bit(CLOCK_FREQUENCY, BAUD_RATE);
  localparam int CNT_W = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int BIT_W = $clog2(UART_DATA_BITS);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CPB - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(UART_DATA_BITS - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

  uart_state_e               state, state_n;
  logic [CNT_W-1:0]          baud_cnt, baud_cnt_n;
  logic [BIT_W-1:0]          bit_idx, bit_idx_n;
  logic [UART_DATA_BITS-1:0] shift_reg, shift_reg_n;
  logic                      line_n, busy_n;
  logic                      bit_done;

  logic                      push, pop;
  logic [UART_DATA_BITS-1:0] fifo_data;
  logic                      fifo_full, fifo_empty, fifo_empty_next;

  assign push              = tx.transmit_valid && !fifo_full;
  assign tx.transmit_ready = !fifo_full;

  uart_transmit_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (UART_DATA_BITS)
  ) u_fifo (
    .clock      (clock),
    .reset      (reset),
    .push       (push),
    .push_data  (tx.transmit_data),
    .pop        (pop),
    .pop_data   (fifo_data),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .empty_next (fifo_empty_next)
  );

  assign bit_done = (baud_cnt == CNT_LAST);

  always_comb begin
    state_n     = state;
    baud_cnt_n  = baud_cnt;
    bit_idx_n   = bit_idx;
    shift_reg_n = shift_reg;
    line_n      = transmit_uart;
    pop         = 1'b0;

    case (state)
      ST_IDLE: begin
        line_n = UART_IDLE_LEVEL;
        if (!fifo_empty) begin
          pop         = 1'b1;
          shift_reg_n = fifo_data;
          line_n      = UART_START_LEVEL;
          baud_cnt_n  = '0;
          state_n     = ST_START;
        end
      end

      ST_START: begin
        if (bit_done) begin
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          line_n     = shift_reg[0];
          state_n    = ST_DATA;
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end

      ST_DATA: begin
        if (bit_done) begin
          baud_cnt_n = '0;
          if (bit_idx == DATA_LAST) begin
            bit_idx_n = '0;
            line_n    = UART_STOP_LEVEL;
            state_n   = ST_STOP;
          end else begin
            shift_reg_n = shift_reg >> 1;
            line_n      = shift_reg[1];
            bit_idx_n   = bit_idx + BIT_W'(1);
          end
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end

      ST_STOP: begin
        // bit_idx counts stop bits here; a queued byte starts with no idle gap.
        if (bit_done) begin
          baud_cnt_n = '0;
          if (bit_idx == STOP_LAST) begin
            bit_idx_n = '0;
            if (!fifo_empty) begin
              pop         = 1'b1;
              shift_reg_n = fifo_data;
              line_n      = UART_START_LEVEL;
              state_n     = ST_START;
            end else begin
              line_n  = UART_IDLE_LEVEL;
              state_n = ST_IDLE;
            end
          end else begin
            bit_idx_n = bit_idx + BIT_W'(1);
          end
        end else begin
          baud_cnt_n = baud_cnt + CNT_W'(1);
        end
      end

      default: begin
        line_n  = UART_IDLE_LEVEL;
        state_n = ST_IDLE;
      end
    endcase

    busy_n = (state_n != ST_IDLE) || !fifo_empty_next;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      baud_cnt      <= '0;
      bit_idx       <= '0;
      shift_reg     <= '0;
      transmit_uart <= UART_IDLE_LEVEL;
      busy          <= 1'b0;
    end else begin
      state         <= state_n;
      baud_cnt      <= baud_cnt_n;
      bit_idx       <= bit_idx_n;
      shift_reg     <= shift_reg_n;
      transmit_uart <= line_n;
      busy          <= busy_n;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: directed waveform checks plus a line decoder and
// occupancy model scoreboarding randomized traffic.
module tb_uart_transmitter;

  localparam int CLK_F  = 1000;
  localparam int BAUD   = 100;
  localparam int CPB    = CLK_F / BAUD;
  localparam int DEPTH  = 4;
  localparam int FRAME1 = 10 * CPB;
  localparam int FRAME2 = 11 * CPB;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic line1, busy1, line2, busy2;

  uart_transmitter_if tx1();
  uart_transmitter_if tx2();

  uart_transmitter #(
    .BAUD_RATE(BAUD), .CLOCK_FREQUENCY(CLK_F), .FIFO_DEPTH(DEPTH), .STOP_BITS(1)
  ) dut1 (
    .clock(clock), .reset(reset), .tx(tx1.slave), .transmit_uart(line1), .busy(busy1)
  );

  uart_transmitter #(
    .BAUD_RATE(BAUD), .CLOCK_FREQUENCY(CLK_F), .FIFO_DEPTH(DEPTH), .STOP_BITS(2)
  ) dut2 (
    .clock(clock), .reset(reset), .tx(tx2.slave), .transmit_uart(line2), .busy(busy2)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int n_stall = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Ideal frame level for bit slot k: start, 8 data bits LSB first, then stop bits.
  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    return 1'b1;
  endfunction

  // Line decoder for dut1 and a FIFO occupancy model (accepted minus frames started).
  logic [7:0] dec_q[$];
  logic [7:0] exp_q[$];
  int         start_q[$];
  bit         mon_on = 1'b0;
  int         mon_t = 0;
  logic [7:0] mon_byte = '0;
  int         cyc = 0;
  int         n_acc = 0;
  int         n_start = 0;
  bit         acc_pend = 1'b0;

  always @(negedge clock) begin
    int k;
    cyc++;
    if (!reset) begin
      mon_on   = 1'b0;
      acc_pend = 1'b0;
      n_acc    = 0;
      n_start  = 0;
    end else begin
      if (acc_pend) n_acc++;
      if (!mon_on) begin
        if (line1 == 1'b0) begin
          mon_on = 1'b1;
          mon_t  = 0;
          n_start++;
          start_q.push_back(cyc);
        end
      end else begin
        mon_t++;
      end
      if (mon_on && (mon_t % CPB) == CPB / 2) begin
        k = mon_t / CPB;
        if (k == 0)      check("mon_start", line1, 1'b0);
        else if (k <= 8) mon_byte[k-1] = line1;
        else             check("mon_stop", line1, 1'b1);
      end
      if (mon_on && mon_t == FRAME1 - 1) begin
        dec_q.push_back(mon_byte);
        mon_on = 1'b0;
      end
      check("ready_occ", tx1.transmit_ready, (n_acc - n_start) < DEPTH);
      acc_pend = tx1.transmit_valid && tx1.transmit_ready;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Holds valid until the byte is taken; valid stays high for back-to-back sends.
  task automatic send1(input logic [7:0] b);
    int  g;
    bit  acc;
    g = 0;
    tx1.transmit_data  = b;
    tx1.transmit_valid = 1'b1;
    do begin
      acc = tx1.transmit_ready;
      if (!acc) n_stall++;
      tick();
      g++;
    end while (!acc && g < 1000);
    check("send_timeout", acc, 1'b1);
    exp_q.push_back(b);
  endtask

  task automatic wait_idle(input int max_cyc);
    int g;
    g = 0;
    while (busy1 !== 1'b0 && g < max_cyc) begin
      tick();
      g++;
    end
    check("idle_timeout", busy1, 1'b0);
  endtask

  task automatic sb_flush(input string tag);
    int n;
    check({tag, "_count"}, dec_q.size(), exp_q.size());
    n = (dec_q.size() < exp_q.size()) ? dec_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check({tag, "_byte"}, dec_q[i], exp_q[i]);
    dec_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int s0, g;
    tx1.transmit_valid = 1'b0;
    tx1.transmit_data  = '0;
    tx2.transmit_valid = 1'b0;
    tx2.transmit_data  = '0;

    // Reset values
    repeat (3) @(posedge clock);
    #1;
    check("rst_line", line1, 1'b1);
    check("rst_ready", tx1.transmit_ready, 1'b1);
    check("rst_busy", busy1, 1'b0);
    reset = 1'b1;
    tick();
    check("rst_line2", line2, 1'b1);
    check("rst_ready2", tx2.transmit_ready, 1'b1);
    check("rst_busy2", busy2, 1'b0);

    // Single 0xA5: one-cycle latency, then the exact frame waveform
    tx1.transmit_data  = 8'hA5;
    tx1.transmit_valid = 1'b1;
    tick();
    exp_q.push_back(8'hA5);
    tx1.transmit_valid = 1'b0;
    tx1.transmit_data  = 8'h3B;
    check("a5_lat_pre", line1, 1'b1);
    check("a5_busy_acc", busy1, 1'b1);
    tick();
    for (int t = 0; t < FRAME1; t++) begin
      check("a5_wave", line1, frame_bit(8'hA5, t / CPB));
      if (t == FRAME1 - 1) check("a5_busy_mid", busy1, 1'b1);
      tick();
    end
    check("a5_end_line", line1, 1'b1);
    check("a5_end_busy", busy1, 1'b0);
    sb_flush("a5");

    // Back-to-back with valid held: three contiguous frames
    s0 = start_q.size();
    send1(8'h00);
    send1(8'hFF);
    send1(8'h55);
    tx1.transmit_valid = 1'b0;
    wait_idle(500);
    check("b2b_frames", start_q.size() - s0, 3);
    if (start_q.size() - s0 == 3) begin
      check("b2b_gap1", start_q[s0+1] - start_q[s0], FRAME1);
      check("b2b_gap2", start_q[s0+2] - start_q[s0+1], FRAME1);
    end
    sb_flush("b2b");

    // Burst of 6 into a 4-deep FIFO: must stall, nothing lost
    n_stall = 0;
    for (int i = 0; i < 6; i++) send1(8'($urandom));
    tx1.transmit_valid = 1'b0;
    check("burst_stall", n_stall > 0, 1'b1);
    wait_idle(1000);
    sb_flush("burst");

    // Two stop bits: 0x3C, 110-cycle frame
    tx2.transmit_data  = 8'h3C;
    tx2.transmit_valid = 1'b1;
    tick();
    tx2.transmit_valid = 1'b0;
    g = 0;
    while (line2 !== 1'b0 && g < 20) begin
      tick();
      g++;
    end
    check("sb2_latency", g, 1);
    for (int t = 0; t < FRAME2; t++) begin
      check("sb2_wave", line2, frame_bit(8'h3C, t / CPB));
      tick();
    end
    check("sb2_end_line", line2, 1'b1);
    check("sb2_end_busy", busy2, 1'b0);

    // Reset 35 cycles into a frame with two bytes queued
    send1(8'h11);
    send1(8'h22);
    send1(8'h33);
    tx1.transmit_valid = 1'b0;
    repeat (34) tick();
    check("pre_rst_line", line1, frame_bit(8'h11, 35 / CPB));
    reset = 1'b0;
    #1;
    check("rst_mid_line", line1, 1'b1);
    check("rst_mid_ready", tx1.transmit_ready, 1'b1);
    check("rst_mid_busy", busy1, 1'b0);
    repeat (3) begin
      tick();
      check("rst_hold_line", line1, 1'b1);
      check("rst_hold_ready", tx1.transmit_ready, 1'b1);
    end
    reset = 1'b1;
    dec_q.delete();
    exp_q.delete();
    repeat (20) tick();
    check("no_resume_line", line1, 1'b1);
    check("no_resume_busy", busy1, 1'b0);
    send1(8'h81);
    tx1.transmit_valid = 1'b0;
    wait_idle(300);
    sb_flush("post_rst");

    // Randomized traffic: data toggles while valid is low
    for (int i = 0; i < 200; i++) begin
      repeat ($urandom_range(0, 3)) begin
        tx1.transmit_valid = 1'b0;
        tx1.transmit_data  = 8'($urandom);
        tick();
      end
      send1(8'($urandom));
    end
    tx1.transmit_valid = 1'b0;
    wait_idle(1000);
    sb_flush("rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
